// File: rtl/led_int_ctrl.sv
// Auto-clear handshake for the LED counter interrupt, with count snapshot, event/overrun/error status and a masked irq.
// Clear pulse starts one cycle after the capture and irq_o follows one cycle later; reads return data one cycle after reg_rd_i.
module led_int_ctrl #(
   parameter int unsigned CLR_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic        clk100,
   input  logic        rst,
   input  logic        led_int_i,
   input  logic [31:0] int_cnt_i,
   output logic        int_clr_o,
   output logic        irq_o,
   input  logic        reg_wr_i,
   input  logic        reg_rd_i,
   input  logic [2:0]  reg_addr_i,
   input  logic [31:0] reg_wdata_i,
   output logic [31:0] reg_rdata_o,
   output logic        reg_rvalid_o
);

   typedef enum logic [1:0] {IDLE, CLR, WAIT} state_t;

   localparam logic [3:0]  CLR_LAST = 4'(CLR_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

   state_t      state;
   logic [3:0]  clr_cnt;
   logic [15:0] to_cnt;

   logic        en;
   logic        err_irq_en;
   logic        pending;
   logic        err;
   logic [31:0] snap;
   logic [31:0] evt_cnt;
   logic [15:0] ovr_cnt;

   logic        capture;
   logic        timeout_hit;
   logic        wr_ctrl;
   logic        wr_status;
   logic        wr_ovr;
   logic        w1c_pend;
   logic        w1c_err;
   logic [31:0] rd_mux;
   logic        unused_wdata;

   assign capture     = (state == IDLE) && led_int_i;
   assign timeout_hit = (state == WAIT) && led_int_i && (to_cnt == TO_LAST);
   assign wr_ctrl     = reg_wr_i && (reg_addr_i == 3'd0);
   assign wr_status   = reg_wr_i && (reg_addr_i == 3'd1);
   assign wr_ovr      = reg_wr_i && (reg_addr_i == 3'd4);
   assign w1c_pend    = wr_status && reg_wdata_i[0];
   assign w1c_err     = wr_status && reg_wdata_i[1];
   assign unused_wdata = ^reg_wdata_i[31:2];

   always_ff @(posedge clk100) begin
      if (rst) begin
         state     <= IDLE;
         int_clr_o <= 1'b0;
         clr_cnt   <= 4'd0;
         to_cnt    <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (led_int_i) begin
                  state     <= CLR;
                  int_clr_o <= 1'b1;
                  clr_cnt   <= 4'd0;
               end
            end
            CLR: begin
               if (clr_cnt == CLR_LAST) begin
                  state     <= WAIT;
                  int_clr_o <= 1'b0;
                  to_cnt    <= 16'd0;
               end else begin
                  clr_cnt <= clr_cnt + 4'd1;
               end
            end
            WAIT: begin
               // A dropped level takes priority over a timeout in the same cycle
               if (!led_int_i || (to_cnt == TO_LAST)) state <= IDLE;
               else                                    to_cnt <= to_cnt + 16'd1;
            end
            default: begin
               state     <= IDLE;
               int_clr_o <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      case (reg_addr_i)
         3'd0:    rd_mux = {30'd0, err_irq_en, en};
         3'd1:    rd_mux = {30'd0, err, pending};
         3'd2:    rd_mux = snap;
         3'd3:    rd_mux = evt_cnt;
         3'd4:    rd_mux = {16'd0, ovr_cnt};
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk100) begin
      if (rst) begin
         en           <= 1'b0;
         err_irq_en   <= 1'b0;
         pending      <= 1'b0;
         err          <= 1'b0;
         snap         <= 32'd0;
         evt_cnt      <= 32'd0;
         ovr_cnt      <= 16'd0;
         irq_o        <= 1'b0;
         reg_rvalid_o <= 1'b0;
         reg_rdata_o  <= 32'd0;
      end else begin
         if (wr_ctrl) begin
            en         <= reg_wdata_i[0];
            err_irq_en <= reg_wdata_i[1];
         end

         // A new capture outranks a same-cycle W1C of pending
         if (capture)       pending <= 1'b1;
         else if (w1c_pend) pending <= 1'b0;

         if (timeout_hit)  err <= 1'b1;
         else if (w1c_err) err <= 1'b0;

         if (capture) begin
            snap    <= int_cnt_i;
            evt_cnt <= evt_cnt + 32'd1;
         end

         if (wr_ovr)
            ovr_cnt <= 16'd0;
         else if (capture && pending && !w1c_pend && (ovr_cnt != 16'hFFFF))
            ovr_cnt <= ovr_cnt + 16'd1;

         irq_o        <= en & (pending | (err & err_irq_en));
         reg_rvalid_o <= reg_rd_i;
         reg_rdata_o  <= reg_rd_i ? rd_mux : 32'd0;
      end
   end

endmodule
